mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
Round-robin arbiter that shares the 2:1 select path of the nand-fed mux datapath between two requesters.
- Drives Sel and per-requester grants.
- After every Sel change, waits a programmable settling window so the unequal nand path delays (3 ns vs 4 ns) have resolved before flagging the output valid.
- Enforces a maximum hold time so neither requester starves.

Parameters:
SETTLE_CYC, 2, clock cycles y_valid stays low after Sel changes (0 = no wait)
MAX_HOLD, 8, cycles a grant may be held in SERVE while the other requester waits
CW, 4, width of the settle and hold counters (must hold max(SETTLE_CYC, MAX_HOLD))

Ports:
clk  input  1  single clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
req0  input  1  requester 0 wants the y1 (A/B nand) path, level-held
req1  input  1  requester 1 wants the y2 (C/D nand) path, level-held
Sel  output  1  mux select: 0 = path y1 / req0, 1 = path y2 / req1
gnt0  output  1  grant to requester 0
gnt1  output  1  grant to requester 1
y_valid  output  1  mux output settled and owned by the granted requester
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: rst_n low at a posedge forces the following, regardless of current state (including mid-SETTLE or mid-SERVE):
  - state = IDLE
  - Sel = 0, gnt0 = gnt1 = 0, y_valid = 0, busy = 0
  - last = 1 (so req0 wins the first tie)
  - settle_cnt = hold_cnt = 0
- All outputs are registered. gnt0/gnt1 are never high together.
- States:
  - IDLE: no grant.
    - Winner rules: only one req high -> that requester; both high -> the requester not equal to last; neither -> stay in IDLE.
    - On a winner w: gnt_w = 1, last = w, hold_cnt = 0.
    - If w equals current Sel, or SETTLE_CYC = 0 -> SERVE, with y_valid = 1 on the same edge.
    - Otherwise Sel = w, settle_cnt = SETTLE_CYC, go to SETTLE with y_valid = 0.
  - SETTLE: grant held, y_valid = 0, settle_cnt decrements each cycle.
    - When settle_cnt = 1 at the edge -> SERVE and y_valid = 1.
    - Granted req dropping has priority over the countdown: next state IDLE, grant and y_valid = 0, Sel unchanged.
  - SERVE: grant held, y_valid = 1.
    - hold_cnt increments each cycle and saturates at MAX_HOLD.
    - Granted req low -> IDLE, grant and y_valid = 0, Sel unchanged.
    - Else if hold_cnt = MAX_HOLD and the other req is high -> forced switch in one edge:
      - old grant = 0, new grant = 1, Sel toggles, last = new requester
      - hold_cnt = 0, y_valid = 0
      - settle_cnt = SETTLE_CYC -> SETTLE (or directly SERVE with y_valid = 1 if SETTLE_CYC = 0)
    - hold_cnt = MAX_HOLD with the other req low -> remain in SERVE.
- Latency:
  - IDLE to grant: 1 edge.
  - Grant to y_valid: 0 extra edges if Sel is unchanged, SETTLE_CYC extra edges if Sel changes.
  - Release to grant low: 1 edge.
- Simultaneous release of the granted req and a forced switch: release wins -> IDLE. The other requester is granted on the next IDLE evaluation, with priority set by last.
- Counters use CW-bit unsigned arithmetic with no wrap: settle_cnt stops at 0, hold_cnt saturates.

Test Plan:
1. Reset with req0 = req1 = 1 held -> all outputs 0; first edge after rst_n = 1 gives gnt0 = 1, Sel = 0, y_valid = 1 (no settle, Sel unchanged).
2. req1 alone from IDLE (Sel = 0) -> edge 1: gnt1 = 1, Sel = 1, y_valid = 0; edges 2..3: y_valid low then high at edge 3 (SETTLE_CYC = 2).
3. Both req held continuously -> gnt0 for 8 SERVE cycles, then a one-edge swap to gnt1 with y_valid = 0 for 2 cycles; alternation repeats, never both grants high.
4. req1 drops during SETTLE -> next edge gnt1 = 0, y_valid = 0, state IDLE, Sel stays 1.
5. rst_n low for one edge mid-SERVE (gnt1 = 1, Sel = 1) -> next edge Sel = 0, grants = 0, y_valid = 0, busy = 0.
6. SETTLE_CYC = 0 build, req1 then req0 -> every grant produces y_valid on the same edge; Sel toggles with no low gap beyond the IDLE cycle.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter sharing the 2:1 select path of the nand-fed mux between
// two requesters, with a settling window after each Sel change and a hold limit.
module mux_sel_arbiter #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned CW         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic Sel,
  output logic gnt0,
  output logic gnt1,
  output logic y_valid,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SERVE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] HOLD_MAX    = CW'(MAX_HOLD);
  localparam logic          NO_SETTLE   = (SETTLE_CYC == 0);

  state_t        r_state;
  logic          r_sel;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_y_valid;
  logic          r_busy;
  logic          r_last;
  logic [CW-1:0] r_settle_cnt;
  logic [CW-1:0] r_hold_cnt;

  logic w_any_req;
  logic w_win;
  logic w_own_req;
  logic w_other_req;
  logic w_hold_max;

  // Tie goes to the requester that was not served last; the owner always matches Sel.
  assign w_any_req   = req0 | req1;
  assign w_win       = (req0 & req1) ? ~r_last : req1;
  assign w_own_req   = r_sel ? req1 : req0;
  assign w_other_req = r_sel ? req0 : req1;
  assign w_hold_max  = (r_hold_cnt == HOLD_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_y_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_last       <= 1'b1;
      r_settle_cnt <= '0;
      r_hold_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt0     <= ~w_win;
            r_gnt1     <= w_win;
            r_last     <= w_win;
            r_sel      <= w_win;
            r_hold_cnt <= '0;
            r_busy     <= 1'b1;
            if ((w_win == r_sel) || NO_SETTLE) begin
              r_state   <= ST_SERVE;
              r_y_valid <= 1'b1;
            end else begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= SETTLE_INIT;
              r_y_valid    <= 1'b0;
            end
          end
        end

        ST_SETTLE: begin
          if (!w_own_req) begin
            r_state      <= ST_IDLE;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_y_valid    <= 1'b0;
            r_busy       <= 1'b0;
            r_settle_cnt <= '0;
          end else if (r_settle_cnt == CW'(1)) begin
            r_state      <= ST_SERVE;
            r_y_valid    <= 1'b1;
            r_settle_cnt <= '0;
          end else if (r_settle_cnt != '0) begin
            r_settle_cnt <= r_settle_cnt - CW'(1);
          end
        end

        ST_SERVE: begin
          if (!w_own_req) begin
            r_state   <= ST_IDLE;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_y_valid <= 1'b0;
            r_busy    <= 1'b0;
          end else if (w_hold_max && w_other_req) begin
            // Forced handover: swap grants and Sel on a single edge.
            r_gnt0     <= r_sel;
            r_gnt1     <= ~r_sel;
            r_sel      <= ~r_sel;
            r_last     <= ~r_sel;
            r_hold_cnt <= '0;
            if (NO_SETTLE) begin
              r_state   <= ST_SERVE;
              r_y_valid <= 1'b1;
            end else begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= SETTLE_INIT;
              r_y_valid    <= 1'b0;
            end
          end else if (!w_hold_max) begin
            r_hold_cnt <= r_hold_cnt + CW'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_gnt0    <= 1'b0;
          r_gnt1    <= 1'b0;
          r_y_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign Sel     = r_sel;
  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign y_valid = r_y_valid;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: default build plus a zero-settle build.
module tb_mux_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1;
  logic Sel, gnt0, gnt1, y_valid, busy;
  logic z_req0, z_req1;
  logic z_sel, z_gnt0, z_gnt1, z_y_valid, z_busy;

  int checks = 0;
  int errors = 0;

  // Observation vectors: {Sel, gnt0, gnt1, y_valid, busy}
  logic [4:0] obs;
  logic [4:0] z_obs;
  assign obs   = {Sel, gnt0, gnt1, y_valid, busy};
  assign z_obs = {z_sel, z_gnt0, z_gnt1, z_y_valid, z_busy};

  always #5 clk = ~clk;

  mux_sel_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .Sel(Sel), .gnt0(gnt0), .gnt1(gnt1), .y_valid(y_valid), .busy(busy)
  );

  mux_sel_arbiter #(.SETTLE_CYC(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .req0(z_req0), .req1(z_req1),
    .Sel(z_sel), .gnt0(z_gnt0), .gnt1(z_gnt1), .y_valid(z_y_valid), .busy(z_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; z_req0 = 1'b0; z_req1 = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL reset_outputs: got %b exp %b", obs, 5'b00000); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b01011) begin errors++; $display("FAIL reset_first_grant: got %b exp %b", obs, 5'b01011); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL reset_release: got %b exp %b", obs, 5'b00000); end
  endtask

  task automatic test_req1_alone();
    req1 = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b10101) begin errors++; $display("FAIL req1_edge1: got %b exp %b", obs, 5'b10101); end
    tick();
    checks++;
    if (obs !== 5'b10101) begin errors++; $display("FAIL req1_edge2: got %b exp %b", obs, 5'b10101); end
    tick();
    checks++;
    if (obs !== 5'b10111) begin errors++; $display("FAIL req1_edge3: got %b exp %b", obs, 5'b10111); end
    req1 = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b10000) begin errors++; $display("FAIL req1_release: got %b exp %b", obs, 5'b10000); end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b01011) begin errors++; $display("FAIL b2b_grant0: got %b exp %b", obs, 5'b01011); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (obs !== 5'b01011) begin errors++; $display("FAIL b2b_hold0[%0d]: got %b exp %b", k, obs, 5'b01011); end
    end
    tick();
    checks++;
    if (obs !== 5'b10101) begin errors++; $display("FAIL b2b_swap_to1: got %b exp %b", obs, 5'b10101); end
    tick();
    checks++;
    if (obs !== 5'b10101) begin errors++; $display("FAIL b2b_settle1: got %b exp %b", obs, 5'b10101); end
    tick();
    checks++;
    if (obs !== 5'b10111) begin errors++; $display("FAIL b2b_valid1: got %b exp %b", obs, 5'b10111); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (obs !== 5'b10111) begin errors++; $display("FAIL b2b_hold1[%0d]: got %b exp %b", k, obs, 5'b10111); end
    end
    tick();
    checks++;
    if (obs !== 5'b01001) begin errors++; $display("FAIL b2b_swap_to0: got %b exp %b", obs, 5'b01001); end
    tick();
    checks++;
    if (obs !== 5'b01001) begin errors++; $display("FAIL b2b_settle0: got %b exp %b", obs, 5'b01001); end
    tick();
    checks++;
    if (obs !== 5'b01011) begin errors++; $display("FAIL b2b_valid0: got %b exp %b", obs, 5'b01011); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL b2b_release: got %b exp %b", obs, 5'b00000); end
  endtask

  task automatic test_drop_settle();
    req1 = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b10101) begin errors++; $display("FAIL drop_grant: got %b exp %b", obs, 5'b10101); end
    req1 = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b10000) begin errors++; $display("FAIL drop_in_settle: got %b exp %b", obs, 5'b10000); end
  endtask

  task automatic test_reset_mid_serve();
    req1 = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b10111) begin errors++; $display("FAIL rst_mid_grant_same_sel: got %b exp %b", obs, 5'b10111); end
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL rst_mid_serve: got %b exp %b", obs, 5'b00000); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b10101) begin errors++; $display("FAIL rst_mid_regrant: got %b exp %b", obs, 5'b10101); end
    req1 = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b10000) begin errors++; $display("FAIL rst_mid_release: got %b exp %b", obs, 5'b10000); end
  endtask

  task automatic test_release_vs_switch();
    // last = 1 here, so the tie goes to requester 0 and Sel must move back to 0.
    req0 = 1'b1; req1 = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b01001) begin errors++; $display("FAIL rvs_tie_grant: got %b exp %b", obs, 5'b01001); end
    tick(); tick();
    checks++;
    if (obs !== 5'b01011) begin errors++; $display("FAIL rvs_valid: got %b exp %b", obs, 5'b01011); end
    for (int k = 1; k <= 8; k++) tick();
    req0 = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL rvs_release_wins: got %b exp %b", obs, 5'b00000); end
    tick();
    checks++;
    if (obs !== 5'b10101) begin errors++; $display("FAIL rvs_other_next: got %b exp %b", obs, 5'b10101); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_hold_saturate();
    req0 = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (obs !== 5'b01011) begin errors++; $display("FAIL sat_serve0: got %b exp %b", obs, 5'b01011); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (obs !== 5'b01011) begin errors++; $display("FAIL sat_hold[%0d]: got %b exp %b", k, obs, 5'b01011); end
    end
    req1 = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b10101) begin errors++; $display("FAIL sat_switch: got %b exp %b", obs, 5'b10101); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b10000) begin errors++; $display("FAIL sat_release: got %b exp %b", obs, 5'b10000); end
  endtask

  task automatic test_zero_settle();
    z_req1 = 1'b1;
    tick();
    checks++;
    if (z_obs !== 5'b10111) begin errors++; $display("FAIL z_grant1: got %b exp %b", z_obs, 5'b10111); end
    z_req1 = 1'b0; z_req0 = 1'b1;
    tick();
    checks++;
    if (z_obs !== 5'b10000) begin errors++; $display("FAIL z_idle_gap: got %b exp %b", z_obs, 5'b10000); end
    tick();
    checks++;
    if (z_obs !== 5'b01011) begin errors++; $display("FAIL z_grant0: got %b exp %b", z_obs, 5'b01011); end
    z_req1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (z_obs !== 5'b01011) begin errors++; $display("FAIL z_hold0[%0d]: got %b exp %b", k, z_obs, 5'b01011); end
    end
    tick();
    checks++;
    if (z_obs !== 5'b10111) begin errors++; $display("FAIL z_forced_switch: got %b exp %b", z_obs, 5'b10111); end
    z_req0 = 1'b0; z_req1 = 1'b0;
    tick();
    checks++;
    if (z_obs !== 5'b10000) begin errors++; $display("FAIL z_release: got %b exp %b", z_obs, 5'b10000); end
  endtask

  initial begin
    test_reset();
    test_req1_alone();
    test_back_to_back();
    test_drop_settle();
    test_reset_mid_serve();
    test_release_vs_switch();
    test_hold_saturate();
    test_zero_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
